// File: rtl/amt_pkg.sv
// amt_pkg: shared defaults, lane record types and FSM states for the architectural map table.
package amt_pkg;
    localparam int COMMIT_W_D  = 4;
    localparam int N_LOG_D     = 34;
    localparam int PHYS_W_D    = 7;
    localparam int N_REPAIR_D  = 4;
    localparam int EXC_RESET_D = 1;
    localparam int LOG_W_D     = $clog2(N_LOG_D);

    typedef enum logic {IDLE, REPAIR} amtState_t;

    typedef struct packed {
        logic                valid;
        logic [LOG_W_D-1:0]  log;
        logic [PHYS_W_D-1:0] phys;
    } commit_lane_t;

    typedef struct packed {
        logic                mask;
        logic [LOG_W_D-1:0]  addr;
        logic [PHYS_W_D-1:0] data;
    } repair_lane_t;

    function automatic int ceilDiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
endpackage

// File: rtl/amt_regfile.sv
// amt_regfile: N_LOG x PHYS_W mapping flops, multi-port write, async reads, sync identity load.
module amt_regfile #(
    parameter int N_LOG  = 34,
    parameter int PHYS_W = 7,
    parameter int LOG_W  = 6,
    parameter int N_WR   = 4,
    parameter int N_RD   = 9
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          loadId,
    input  logic [N_WR-1:0]               wrEn,
    input  logic [N_WR-1:0][LOG_W-1:0]    wrAddr,
    input  logic [N_WR-1:0][PHYS_W-1:0]   wrData,
    input  logic [N_RD-1:0][LOG_W-1:0]    rdAddr,
    output logic [N_RD-1:0][PHYS_W-1:0]   rdData
);
    logic [PHYS_W-1:0] mem [N_LOG];

    // write addresses are distinct per cycle, so port order never matters
    always_ff @(posedge clk) begin
        if (!reset_n || loadId) begin
            for (int i = 0; i < N_LOG; i++) mem[i] <= PHYS_W'(i);
        end else begin
            for (int w = 0; w < N_WR; w++)
                if (wrEn[w] && ({1'b0, wrAddr[w]} < (LOG_W+1)'(N_LOG))) mem[wrAddr[w]] <= wrData[w];
        end
    end

    always_comb begin
        rdData = '0;
        for (int r = 0; r < N_RD; r++)
            rdData[r] = ({1'b0, rdAddr[r]} < (LOG_W+1)'(N_LOG)) ? mem[rdAddr[r]] : '0;
    end
endmodule

// File: rtl/arch_map_table_gen.sv
// arch_map_table_gen: retire-stage AMT with commit/free logic and a restartable,
// back-pressured repair stream to the RMT.
module arch_map_table_gen
    import amt_pkg::*;
#(
    parameter int COMMIT_W  = COMMIT_W_D,
    parameter int N_LOG     = N_LOG_D,
    parameter int PHYS_W    = PHYS_W_D,
    parameter int N_REPAIR  = N_REPAIR_D,
    parameter int EXC_RESET = EXC_RESET_D,
    localparam int LOG_W    = $clog2(N_LOG),
    localparam int N_CYC    = ceilDiv(N_LOG, N_REPAIR),
    localparam int CNT_W    = $clog2(N_CYC + 1)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [COMMIT_W-1:0]                 commit_valid_i,
    input  logic [COMMIT_W-1:0][LOG_W-1:0]      commit_log_i,
    input  logic [COMMIT_W-1:0][PHYS_W-1:0]     commit_phys_i,
    output logic [COMMIT_W-1:0]                 freed_valid_o,
    output logic [COMMIT_W-1:0][PHYS_W-1:0]     freed_phys_o,
    input  logic                                recover_i,
    input  logic                                exception_i,
    input  logic                                repair_ready_i,
    output logic                                repair_valid_o,
    output logic [N_REPAIR-1:0]                 repair_mask_o,
    output logic [N_REPAIR-1:0][LOG_W-1:0]      repair_addr_o,
    output logic [N_REPAIR-1:0][PHYS_W-1:0]     repair_data_o,
    output logic                                repair_done_o,
    output logic                                busy_o,
    input  logic [LOG_W-1:0]                    dbg_addr_i,
    output logic [PHYS_W-1:0]                   dbg_data_o
);
    localparam int N_RD = COMMIT_W + N_REPAIR + 1;

    amtState_t state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic doneQ, doneNext;
    logic repairReq, loadId, commitOk;
    logic [COMMIT_W-1:0] superseded, wrEn;
    logic [N_RD-1:0][LOG_W-1:0] rdAddr;
    logic [N_RD-1:0][PHYS_W-1:0] rdData;

    assign repairReq = recover_i | exception_i;
    assign loadId    = (EXC_RESET != 0) && exception_i;
    // identity reload wins over anything committing alongside the exception
    assign commitOk  = (state == IDLE) && !loadId;

    for (genvar j = 0; j < COMMIT_W; j++) begin : gLane
        logic [COMMIT_W-1:0] younger;
        for (genvar k = 0; k < COMMIT_W; k++) begin : gCmp
            if (k > j) begin : gHit
                assign younger[k] = commit_valid_i[k] && (commit_log_i[k] == commit_log_i[j]);
            end else begin : gNone
                assign younger[k] = 1'b0;
            end
        end
        assign superseded[j]    = |younger;
        assign wrEn[j]          = commitOk && commit_valid_i[j] && !superseded[j];
        assign rdAddr[j]        = commit_log_i[j];
        assign freed_valid_o[j] = commitOk && commit_valid_i[j];
        assign freed_phys_o[j]  = superseded[j] ? commit_phys_i[j] : rdData[j];
    end

    // lane k walks a contiguous slice of N_CYC entries starting at k*N_CYC
    for (genvar k = 0; k < N_REPAIR; k++) begin : gRep
        logic [LOG_W:0] addr;
        assign addr                  = (LOG_W+1)'(k * N_CYC) + (LOG_W+1)'(cnt);
        assign repair_mask_o[k]      = addr < (LOG_W+1)'(N_LOG);
        assign rdAddr[COMMIT_W + k]  = addr[LOG_W-1:0];
        assign repair_addr_o[k]      = repair_mask_o[k] ? addr[LOG_W-1:0] : '0;
        assign repair_data_o[k]      = repair_mask_o[k] ? rdData[COMMIT_W + k] : '0;
    end

    assign rdAddr[N_RD-1] = dbg_addr_i;
    assign dbg_data_o     = rdData[N_RD-1];

    amt_regfile #(
        .N_LOG(N_LOG), .PHYS_W(PHYS_W), .LOG_W(LOG_W), .N_WR(COMMIT_W), .N_RD(N_RD)
    ) uRegfile (
        .clk(clk),
        .reset_n(reset_n),
        .loadId(loadId),
        .wrEn(wrEn),
        .wrAddr(commit_log_i),
        .wrData(commit_phys_i),
        .rdAddr(rdAddr),
        .rdData(rdData)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            doneQ <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            doneQ <= doneNext;
        end
    end

    // a new request restarts the pass and suppresses the done pulse of the aborted one
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        doneNext  = 1'b0;
        if (repairReq) begin
            stateNext = REPAIR;
            cntNext   = '0;
        end else if (state == REPAIR && repair_ready_i) begin
            stateNext = (cnt == CNT_W'(N_CYC - 1)) ? IDLE : REPAIR;
            doneNext  = (cnt == CNT_W'(N_CYC - 1));
            cntNext   = (cnt == CNT_W'(N_CYC - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign busy_o         = (state == REPAIR);
    assign repair_valid_o = (state == REPAIR);
    assign repair_done_o  = doneQ;
endmodule

// File: tb/tb_arch_map_table_gen.sv
// tb_arch_map_table_gen: directed stimulus with a per-cycle behavioural AMT model and literal checkpoints.
module tb_arch_map_table_gen;
    localparam int COMMIT_W = 4, N_LOG = 34, PHYS_W = 7, N_REPAIR = 4, EXC_RESET = 1;
    localparam int LOG_W = 6, N_CYC = 9;

    logic clk = 1'b0;
    logic reset_n;
    logic [COMMIT_W-1:0] commit_valid_i;
    logic [COMMIT_W-1:0][LOG_W-1:0] commit_log_i;
    logic [COMMIT_W-1:0][PHYS_W-1:0] commit_phys_i;
    logic [COMMIT_W-1:0] freed_valid_o;
    logic [COMMIT_W-1:0][PHYS_W-1:0] freed_phys_o;
    logic recover_i, exception_i, repair_ready_i, repair_valid_o, repair_done_o, busy_o;
    logic [N_REPAIR-1:0] repair_mask_o;
    logic [N_REPAIR-1:0][LOG_W-1:0] repair_addr_o;
    logic [N_REPAIR-1:0][PHYS_W-1:0] repair_data_o;
    logic [LOG_W-1:0] dbg_addr_i;
    logic [PHYS_W-1:0] dbg_data_o;

    always #5 clk = ~clk;

    arch_map_table_gen #(
        .COMMIT_W(COMMIT_W), .N_LOG(N_LOG), .PHYS_W(PHYS_W), .N_REPAIR(N_REPAIR), .EXC_RESET(EXC_RESET)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .commit_valid_i(commit_valid_i), .commit_log_i(commit_log_i), .commit_phys_i(commit_phys_i),
        .freed_valid_o(freed_valid_o), .freed_phys_o(freed_phys_o),
        .recover_i(recover_i), .exception_i(exception_i), .repair_ready_i(repair_ready_i),
        .repair_valid_o(repair_valid_o), .repair_mask_o(repair_mask_o), .repair_addr_o(repair_addr_o),
        .repair_data_o(repair_data_o), .repair_done_o(repair_done_o), .busy_o(busy_o),
        .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
    );

    int total = 0, bad = 0;
    int doneCnt = 0, acceptCnt = 0, illegal = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // model: plain array of mappings plus repair progress
    int amt [N_LOG];
    int newAmt [N_LOG];
    bit modelOk = 0, rep = 0, doneExp = 0;
    int beat = 0;

    always @(negedge clk) begin
        logic [COMMIT_W-1:0] expV;
        int a, e;
        bit sup;
        if (modelOk) begin
            chk("busy", 32'(busy_o), 32'(rep));
            chk("repair_valid", 32'(repair_valid_o), 32'(rep));
            chk("done", 32'(repair_done_o), 32'(doneExp));
            chk("dbg", 32'(dbg_data_o), 32'(amt[dbg_addr_i]));
            for (int j = 0; j < COMMIT_W; j++)
                expV[j] = commit_valid_i[j] && !rep && !(EXC_RESET != 0 && exception_i);
            chk("freed_valid", 32'(freed_valid_o), 32'(expV));
            for (int j = 0; j < COMMIT_W; j++) if (expV[j]) begin
                sup = 0;
                for (int k = j + 1; k < COMMIT_W; k++)
                    if (commit_valid_i[k] && commit_log_i[k] == commit_log_i[j]) sup = 1;
                e = sup ? int'(commit_phys_i[j]) : amt[commit_log_i[j]];
                chk("freed_phys", 32'(freed_phys_o[j]), 32'(e));
            end
            if (rep) for (int k = 0; k < N_REPAIR; k++) begin
                a = k * N_CYC + beat;
                chk("repair_mask", 32'(repair_mask_o[k]), 32'(a < N_LOG));
                chk("repair_addr", 32'(repair_addr_o[k]), a < N_LOG ? 32'(a) : 32'd0);
                chk("repair_data", 32'(repair_data_o[k]), a < N_LOG ? 32'(amt[a]) : 32'd0);
            end
            if (repair_done_o) doneCnt++;
            if (repair_valid_o && repair_ready_i) acceptCnt++;
            if (rep && |commit_valid_i) begin
                illegal++;
                $display("note: commit during repair ignored (%0d so far)", illegal);
            end
        end
        if (!reset_n) begin
            for (int i = 0; i < N_LOG; i++) amt[i] = i;
            rep = 0; beat = 0; doneExp = 0; modelOk = 1;
        end else if (modelOk) begin
            newAmt = amt;
            if (EXC_RESET != 0 && exception_i) begin
                for (int i = 0; i < N_LOG; i++) newAmt[i] = i;
            end else if (!rep) begin
                for (int j = 0; j < COMMIT_W; j++)
                    if (commit_valid_i[j]) newAmt[commit_log_i[j]] = int'(commit_phys_i[j]);
            end
            amt = newAmt;
            doneExp = 0;
            if (recover_i || exception_i) begin
                rep = 1; beat = 0;
            end else if (rep && repair_ready_i) begin
                if (beat == N_CYC - 1) begin rep = 0; beat = 0; doneExp = 1; end
                else beat++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setLane(input int j, input int l, input int p);
        commit_valid_i[j] = 1'b1;
        commit_log_i[j]   = LOG_W'(l);
        commit_phys_i[j]  = PHYS_W'(p);
    endtask

    task automatic clearLanes();
        commit_valid_i = '0; commit_log_i = '0; commit_phys_i = '0;
    endtask

    int a0, d0, c;

    initial begin
        reset_n = 1'b0; recover_i = 1'b0; exception_i = 1'b0; repair_ready_i = 1'b1;
        dbg_addr_i = 6'd5;
        clearLanes();
        repeat (2) tick();
        chk("reset_dbg_r5", 32'(dbg_data_o), 32'd5);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_freed", 32'(freed_valid_o), 32'd0);
        reset_n = 1'b1;
        tick();

        setLane(0, 3, 40); setLane(1, 3, 41); setLane(2, 7, 42); setLane(3, 3, 43);
        #1;
        chk("freed0", 32'(freed_phys_o[0]), 32'd40);
        chk("freed1", 32'(freed_phys_o[1]), 32'd41);
        chk("freed2", 32'(freed_phys_o[2]), 32'd7);
        chk("freed3", 32'(freed_phys_o[3]), 32'd3);
        tick();
        clearLanes();
        dbg_addr_i = 6'd3; #1 chk("amt_r3", 32'(dbg_data_o), 32'd43);
        dbg_addr_i = 6'd7; #1 chk("amt_r7", 32'(dbg_data_o), 32'd42);

        a0 = acceptCnt; d0 = doneCnt;
        recover_i = 1'b1;
        tick();
        recover_i = 1'b0;
        for (int b = 0; b < N_CYC; b++) begin
            if (b == 3) chk("beat3_lane0_data", 32'(repair_data_o[0]), 32'd43);
            if (b == 8) begin
                chk("beat8_mask", 32'(repair_mask_o), 32'b0111);
                chk("beat8_addr0", 32'(repair_addr_o[0]), 32'd8);
                chk("beat8_addr1", 32'(repair_addr_o[1]), 32'd17);
                chk("beat8_addr2", 32'(repair_addr_o[2]), 32'd26);
                chk("beat8_addr3", 32'(repair_addr_o[3]), 32'd0);
            end
            tick();
        end
        chk("done_cycle10", 32'(repair_done_o), 32'd1);
        chk("busy_after", 32'(busy_o), 32'd0);
        tick();
        chk("done_once", 32'(doneCnt - d0), 32'd1);
        chk("beats_t3", 32'(acceptCnt - a0), 32'd9);

        a0 = acceptCnt;
        recover_i = 1'b1;
        tick();
        recover_i = 1'b0;
        for (c = 0; c < 40 && !repair_done_o; c++) begin
            repair_ready_i = !(c >= 2 && c <= 4);
            clearLanes();
            if (c == 3) setLane(0, 9, 60);
            #1;
            if (c >= 2 && c <= 4) chk("hold_addr", 32'(repair_addr_o[0]), 32'd2);
            tick();
        end
        clearLanes();
        repair_ready_i = 1'b1;
        chk("done_t4", 32'(repair_done_o), 32'd1);
        chk("beats_t4", 32'(acceptCnt - a0), 32'd9);
        tick();
        dbg_addr_i = 6'd9; #1 chk("illegal_no_write", 32'(dbg_data_o), 32'd9);

        d0 = doneCnt;
        recover_i = 1'b1;
        tick();
        recover_i = 1'b0;
        repeat (5) tick();
        chk("beat5_addr", 32'(repair_addr_o[0]), 32'd5);
        recover_i = 1'b1;
        tick();
        recover_i = 1'b0;
        a0 = acceptCnt;
        chk("restart_addr", 32'(repair_addr_o[0]), 32'd0);
        for (c = 0; c < 40 && !repair_done_o; c++) tick();
        chk("done_t5", 32'(repair_done_o), 32'd1);
        tick();
        chk("beats_t5", 32'(acceptCnt - a0), 32'd9);
        chk("single_done_t5", 32'(doneCnt - d0), 32'd1);

        exception_i = 1'b1;
        setLane(0, 3, 50);
        #1;
        chk("exc_freed_valid", 32'(freed_valid_o), 32'd0);
        tick();
        exception_i = 1'b0;
        clearLanes();
        dbg_addr_i = 6'd3; #1 chk("exc_r3", 32'(dbg_data_o), 32'd3);
        repeat (3) tick();
        chk("exc_beat3_data", 32'(repair_data_o[0]), 32'd3);
        for (c = 0; c < 40 && !repair_done_o; c++) tick();
        chk("done_t6", 32'(repair_done_o), 32'd1);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
